// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: RAM word width and the dump sequencer's state encoding.
package sap_pkg;

  localparam int SAP_WORD_WIDTH = 16;
  localparam int SAP_BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    DUMP_IDLE,
    DUMP_ISSUE,
    DUMP_WAIT,
    DUMP_SEND_A,
    DUMP_SEND_B,
    DUMP_FINISH
  } dump_state_e;

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one RAM word and presents it as two bytes on a valid/ready interface.
module word_byte_serializer
  import sap_pkg::*;
#(
  parameter int HI_FIRST = 1
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_load,
  input  logic [SAP_WORD_WIDTH-1:0] i_word,
  input  logic                      i_clear,
  input  logic                      i_ready,
  output logic [SAP_BYTE_WIDTH-1:0] o_byte,
  output logic                      o_valid,
  output logic                      o_done
);

  logic [SAP_WORD_WIDTH-1:0] word_q, word_d;
  logic                      valid_q, valid_d;
  logic                      second_q, second_d;
  logic                      handshake;
  logic                      hi_sel;

  assign handshake = valid_q & i_ready;

  always_comb begin
    word_d   = word_q;
    valid_d  = valid_q;
    second_d = second_q;
    if (i_clear) begin
      valid_d  = 1'b0;
      second_d = 1'b0;
    end else if (i_load) begin
      word_d   = i_word;
      valid_d  = 1'b1;
      second_d = 1'b0;
    end else if (handshake) begin
      if (second_q) begin
        valid_d  = 1'b0;
        second_d = 1'b0;
      end else begin
        second_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      word_q   <= '0;
      valid_q  <= 1'b0;
      second_q <= 1'b0;
    end else begin
      word_q   <= word_d;
      valid_q  <= valid_d;
      second_q <= second_d;
    end
  end

  // second_q selects the byte; HI_FIRST decides which half goes out first.
  assign hi_sel  = (HI_FIRST != 0) ? ~second_q : second_q;
  assign o_byte  = hi_sel ? word_q[15:8] : word_q[7:0];
  assign o_valid = valid_q;
  assign o_done  = handshake & second_q & ~i_clear;

endmodule

// File: rtl/ram_dump_reader.sv
// Walks an inclusive RAM address range through the program-mode port and streams each word as two bytes.
//
// state   | meaning
// IDLE    | RAM released, waiting for i_start
// ISSUE   | one-cycle read strobe at the current address
// WAIT    | counting read latency; word captured on the last cycle
// SEND_A  | first byte offered to the sink
// SEND_B  | second byte offered; advances address and word count on handshake
// FINISH  | one-cycle o_done, then back to IDLE
module ram_dump_reader
  import sap_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int HI_FIRST     = 1
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [ADDR_WIDTH-1:0]     i_first_address,
  input  logic [ADDR_WIDTH-1:0]     i_last_address,
  input  logic                      i_abort,
  output logic                      o_program_mode,
  output logic [ADDR_WIDTH-1:0]     o_ram_address,
  output logic                      o_read_enable,
  input  logic [SAP_WORD_WIDTH-1:0] i_ram_data,
  output logic [SAP_BYTE_WIDTH-1:0] o_byte,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int LAT_W = 2;

  dump_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]        words_q, words_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic [ADDR_WIDTH-1:0]   span;
  logic                    busy;
  logic                    ser_load;
  logic                    ser_clear;
  logic                    ser_valid;
  logic                    ser_done;

  // The extra count bit lets last == first-1 express a full 2**AW-word sweep.
  assign span = i_last_address - i_first_address;
  assign busy = (state_q == DUMP_ISSUE) || (state_q == DUMP_WAIT) ||
                (state_q == DUMP_SEND_A) || (state_q == DUMP_SEND_B);
  assign ser_clear = i_abort & busy;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    words_d  = words_q;
    lat_d    = lat_q;
    ser_load = 1'b0;
    case (state_q)
      DUMP_IDLE: begin
        if (i_start && !i_abort) begin
          addr_d  = i_first_address;
          words_d = {1'b0, span} + CNT_W'(1);
          state_d = DUMP_ISSUE;
        end
      end
      DUMP_ISSUE: begin
        if (i_abort) begin
          state_d = DUMP_FINISH;
        end else begin
          lat_d   = LAT_W'(READ_LATENCY - 1);
          state_d = DUMP_WAIT;
        end
      end
      DUMP_WAIT: begin
        if (i_abort) begin
          state_d = DUMP_FINISH;
        end else if (lat_q == '0) begin
          ser_load = 1'b1;
          state_d  = DUMP_SEND_A;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      DUMP_SEND_A: begin
        if (i_abort) begin
          state_d = DUMP_FINISH;
        end else if (ser_valid && i_ready) begin
          state_d = DUMP_SEND_B;
        end
      end
      DUMP_SEND_B: begin
        if (i_abort) begin
          state_d = DUMP_FINISH;
        end else if (ser_done) begin
          words_d = words_q - CNT_W'(1);
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = (words_q == CNT_W'(1)) ? DUMP_FINISH : DUMP_ISSUE;
        end
      end
      DUMP_FINISH: state_d = DUMP_IDLE;
      default:     state_d = DUMP_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= DUMP_IDLE;
      addr_q  <= '0;
      words_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      lat_q   <= lat_d;
    end
  end

  word_byte_serializer #(
    .HI_FIRST (HI_FIRST)
  ) u_serializer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (ser_load),
    .i_word  (i_ram_data),
    .i_clear (ser_clear),
    .i_ready (i_ready),
    .o_byte  (o_byte),
    .o_valid (ser_valid),
    .o_done  (ser_done)
  );

  assign o_valid        = ser_valid;
  assign o_busy         = busy;
  assign o_program_mode = busy;
  assign o_read_enable  = (state_q == DUMP_ISSUE);
  assign o_ram_address  = addr_q;
  assign o_done         = (state_q == DUMP_FINISH);

endmodule

// File: tb/tb_ram_dump_reader.sv
// Bench for ram_dump_reader: two instances (read latency 1 and 3) against a behavioural RAM and stream model.
module tb_ram_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] first_a, last_a;
  logic       rdy;
  logic       start_s [2];
  logic       abort_s [2];
  logic       pm_s    [2];
  logic [7:0] addr_s  [2];
  logic       re_s    [2];
  logic [15:0] rdata_s [2];
  logic [7:0] byte_s  [2];
  logic       valid_s [2];
  logic       busy_s  [2];
  logic       done_s  [2];

  ram_dump_reader #(.ADDR_WIDTH(8), .READ_LATENCY(1), .HI_FIRST(1)) dut0 (
    .i_clock(clk), .i_reset(rst), .i_start(start_s[0]), .i_first_address(first_a),
    .i_last_address(last_a), .i_abort(abort_s[0]), .o_program_mode(pm_s[0]),
    .o_ram_address(addr_s[0]), .o_read_enable(re_s[0]), .i_ram_data(rdata_s[0]),
    .o_byte(byte_s[0]), .o_valid(valid_s[0]), .i_ready(rdy), .o_busy(busy_s[0]), .o_done(done_s[0]));

  ram_dump_reader #(.ADDR_WIDTH(8), .READ_LATENCY(3), .HI_FIRST(1)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_start(start_s[1]), .i_first_address(first_a),
    .i_last_address(last_a), .i_abort(abort_s[1]), .o_program_mode(pm_s[1]),
    .o_ram_address(addr_s[1]), .o_read_enable(re_s[1]), .i_ram_data(rdata_s[1]),
    .o_byte(byte_s[1]), .o_valid(valid_s[1]), .i_ready(rdy), .o_busy(busy_s[1]), .o_done(done_s[1]));

  // Behavioural RAM: data is only meaningful exactly READ_LATENCY clocks after a strobe.
  logic [15:0] mem [256];
  logic [15:0] pipe [2][4];
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      pipe[u][0] <= re_s[u] ? mem[addr_s[u]] : 16'($urandom);
      for (int k = 1; k < 4; k++) pipe[u][k] <= pipe[u][k-1];
    end
  end
  assign rdata_s[0] = pipe[0][0];
  assign rdata_s[1] = pipe[1][2];

  int cyc = 0;
  int ready_mode = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: rdy = 1'b1;
      1: rdy = (cyc % 3 == 0);
      2: rdy = 1'($urandom % 2);
      default: ;
    endcase
  end

  // Stream monitor, sampled mid-cycle.
  logic [7:0] addr_log [2][512];
  logic [7:0] byte_log [2][1024];
  int strobe_cnt [2], byte_cnt [2], done_cnt [2], stall_viol [2];
  logic pv [2], pr [2], pa [2], prs [2];
  logic [7:0] pb [2];
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (re_s[u] && strobe_cnt[u] < 512) begin
        addr_log[u][strobe_cnt[u]] = addr_s[u];
        strobe_cnt[u]++;
      end
      if (valid_s[u] && rdy && byte_cnt[u] < 1024) begin
        byte_log[u][byte_cnt[u]] = byte_s[u];
        byte_cnt[u]++;
      end
      if (done_s[u]) done_cnt[u]++;
      if (pv[u] && !pr[u] && !pa[u] && !prs[u] && !(valid_s[u] && byte_s[u] == pb[u]))
        stall_viol[u]++;
      pv[u] = valid_s[u]; pr[u] = rdy; pa[u] = abort_s[u]; prs[u] = rst; pb[u] = byte_s[u];
    end
  end

  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic mon_clear(input int u);
    strobe_cnt[u] = 0; byte_cnt[u] = 0; done_cnt[u] = 0; stall_viol[u] = 0;
  endtask

  // Reference stream: plain modular arithmetic over the address range.
  int exp_n;
  logic [7:0] exp_addr [512];
  logic [7:0] exp_byte [1024];
  task automatic build_expect(input int first, input int last);
    exp_n = ((last - first + 256) % 256) + 1;
    for (int i = 0; i < exp_n; i++) begin
      int a;
      a = (first + i) % 256;
      exp_addr[i]       = 8'(a);
      exp_byte[2*i]     = mem[a][15:8];
      exp_byte[2*i + 1] = mem[a][7:0];
    end
  endtask

  function automatic int first_bad_byte(input int u, input int cnt);
    for (int i = 0; i < cnt; i++)
      if (i >= byte_cnt[u] || byte_log[u][i] !== exp_byte[i]) return i;
    return -1;
  endfunction

  function automatic int first_bad_addr(input int u, input int cnt);
    for (int i = 0; i < cnt; i++)
      if (i >= strobe_cnt[u] || addr_log[u][i] !== exp_addr[i]) return i;
    return -1;
  endfunction

  function automatic longint outs(input int u);
    return longint'({pm_s[u], addr_s[u], re_s[u], byte_s[u], valid_s[u], busy_s[u], done_s[u]});
  endfunction

  task automatic run_dump(input int u, input int first, input int last, input int mode,
                          input int exp_words, input bit poke);
    int d, budget, lat;
    bit timed_out;
    lat = (u == 0) ? 1 : 3;
    build_expect(first, last);
    chk("model_word_count", exp_n, exp_words);
    budget = exp_n * 40 + 100;
    ready_mode = mode;
    @(posedge clk); #1;
    mon_clear(u);
    first_a = 8'(first); last_a = 8'(last);
    start_s[u] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    start_s[u] = 1'b0;
    d = 0; timed_out = 1'b0;
    forever begin
      @(negedge clk);
      d++;
      if (d == 1)
        chk("issue_after_start", longint'({busy_s[u], pm_s[u], re_s[u], addr_s[u]}),
            longint'({3'b111, 8'(first)}));
      if (done_s[u]) break;
      if (d > budget) begin timed_out = 1'b1; break; end
      if (poke && d == 5) begin
        @(posedge clk); #1;
        start_s[u] = 1'b1; first_a = 8'd200; last_a = 8'd100;
      end
      if (poke && d == 6) begin
        @(posedge clk); #1;
        start_s[u] = 1'b0;
      end
    end
    chk("done_timeout", timed_out, 0);
    if (mode == 0 && !timed_out) chk("dump_cycles", d, exp_n * (3 + lat) + 1);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt[u], 1);
    chk("strobe_count", strobe_cnt[u], exp_words);
    chk("addr_first_bad", first_bad_addr(u, exp_n), -1);
    chk("byte_count", byte_cnt[u], 2 * exp_n);
    chk("byte_first_bad", first_bad_byte(u, 2 * exp_n), -1);
    chk("stall_stability", stall_viol[u], 0);
    chk("idle_after_done", longint'({busy_s[u], pm_s[u], valid_s[u]}), 0);
  endtask

  typedef struct {
    int u; int first; int last; int mode; int words; bit poke;
  } vec_t;
  vec_t tbl [7];

  initial begin
    int rc;
    logic seen;
    tbl[0] = '{0,   0,   3, 0,   4, 1'b0};
    tbl[1] = '{0,   5,   5, 0,   1, 1'b0};
    tbl[2] = '{0,   3,   2, 0, 256, 1'b0};
    tbl[3] = '{0, 254,   1, 0,   4, 1'b0};
    tbl[4] = '{0,   0,   3, 1,   4, 1'b0};
    tbl[5] = '{1,   0,   3, 0,   4, 1'b0};
    tbl[6] = '{0,  10,  20, 2,  11, 1'b1};

    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    mem[0] = 16'h00FF; mem[1] = 16'h017F; mem[2] = 16'h0201; mem[3] = 16'h0702;

    rst = 1'b1; rdy = 1'b1; first_a = '0; last_a = '0;
    for (int u = 0; u < 2; u++) begin start_s[u] = 1'b0; abort_s[u] = 1'b0; mon_clear(u); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_u0", outs(0), 0);
    chk("reset_outputs_u1", outs(1), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_dump(tbl[i].u, tbl[i].first, tbl[i].last, tbl[i].mode, tbl[i].words, tbl[i].poke);

    // Abort while the first byte of word 2 is on offer.
    ready_mode = 9;
    @(posedge clk); #1;
    rdy = 1'b1; mon_clear(0); first_a = 8'd0; last_a = 8'd3; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    rc = 0;
    for (int k = 0; k < 100 && rc < 3; k++) begin
      @(negedge clk);
      if (re_s[0]) rc++;
    end
    chk("abort_reached_word2", rc, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rdy = 1'b0; abort_s[0] = 1'b1;
    @(negedge clk);
    chk("abort_in_send_a_valid", valid_s[0], 1);
    @(posedge clk); #1;
    abort_s[0] = 1'b0;
    @(negedge clk);
    chk("abort_next_cycle", longint'({valid_s[0], done_s[0], busy_s[0], re_s[0], pm_s[0]}), 5'b01000);
    @(negedge clk);
    chk("abort_done_single_cycle", done_s[0], 0);
    repeat (3) @(negedge clk);
    build_expect(0, 3);
    chk("abort_done_pulses", done_cnt[0], 1);
    chk("abort_byte_count", byte_cnt[0], 4);
    chk("abort_byte_first_bad", first_bad_byte(0, 4), -1);
    run_dump(0, 0, 3, 0, 4, 1'b0);

    // Reset during WAIT: everything clears, no o_done.
    ready_mode = 0;
    @(posedge clk); #1;
    mon_clear(0); first_a = 8'd7; last_a = 8'd9; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    rc = 0;
    for (int k = 0; k < 20 && rc == 0; k++) begin
      @(negedge clk);
      if (re_s[0]) rc++;
    end
    chk("reset_test_reached_issue", rc, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mid_wait_outputs", outs(0), 0);
    repeat (10) @(negedge clk);
    chk("reset_mid_wait_no_done", done_cnt[0], 0);

    // Start and abort together in IDLE: abort wins.
    @(posedge clk); #1;
    mon_clear(0); first_a = 8'd4; last_a = 8'd6; start_s[0] = 1'b1; abort_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0; abort_s[0] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= busy_s[0] | re_s[0] | done_s[0] | pm_s[0];
    end
    chk("start_abort_same_cycle", seen, 0);

    for (int i = 0; i < 8; i++) begin
      int f, len;
      f = int'($urandom % 256);
      len = int'($urandom % 8);
      run_dump(int'($urandom % 2), f, (f + len) % 256, int'($urandom % 3), len + 1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
